// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared types and defaults for the key event encoder
package key_event_pkg;

  localparam int DEFAULT_KEYS = 61;
  localparam int DEFAULT_IDXW = 6;

  typedef struct packed {
    logic                    pressed;
    logic [DEFAULT_IDXW-1:0] idx;
  } key_event_t;

  typedef enum logic {
    SCAN  = 1'b0,
    STALL = 1'b1
  } scan_state_t;

endpackage

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - first-word fall-through event FIFO
// Head entry is read straight from storage; the output is forced to zero while empty.
module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  output logic                   full,
  input  logic                   pop,
  output logic                   valid,
  output logic [W-1:0]           pop_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop_fire;

  // Full comes from the registered level, so a same-cycle pop never frees a slot for a push.
  assign full      = (level == (AW+1)'(DEPTH));
  assign valid     = (level != '0);
  assign push_fire = push && !full;
  assign pop_fire  = pop && valid;
  assign pop_data  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      if (push_fire && !pop_fire)      level <= level + 1'b1;
      else if (pop_fire && !push_fire) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/key_event_encoder.sv
// rtl/key_event_encoder.sv - round-robin key scanner feeding a press/release event FIFO
// Optional KEY_EVENT_TIMESTAMP_EN stores a free-running tick count with each event.
module key_event_encoder
  import key_event_pkg::*;
#(
  parameter int KEYS  = DEFAULT_KEYS,
  parameter int IDXW  = DEFAULT_IDXW,
  parameter int DEPTH = 8,
  parameter int TSW   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [KEYS-1:0]        keys_i,
  output logic                   event_valid_o,
  input  logic                   event_ready_i,
  output logic [IDXW:0]          event_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
`ifdef KEY_EVENT_TIMESTAMP_EN
  output logic [TSW-1:0]         event_ts_o,
`endif
  output logic                   stall_o
);

`ifdef KEY_EVENT_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int PW = IDXW + 1 + (TS_EN ? TSW : 0);

  scan_state_t     state, state_nxt;
  logic [IDXW-1:0] ptr;
  logic [KEYS-1:0] snap;
  logic            level_now;
  logic            differs;
  logic            full;
  logic            push;
  logic            advance;
  logic [PW-1:0]   push_data;
  logic [PW-1:0]   head;

  assign level_now = keys_i[ptr];
  assign differs   = level_now ^ snap[ptr];
  assign stall_o   = (state == STALL);

`ifdef KEY_EVENT_TIMESTAMP_EN
  logic [TSW-1:0] ts;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts <= '0;
    else         ts <= ts + 1'b1;
  end

  assign push_data  = {ts, level_now, ptr};
  assign event_ts_o = head[PW-1:IDXW+1];
`else
  assign push_data  = {level_now, ptr};
`endif

  assign event_o = head[IDXW:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= SCAN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:    if (differs && full) state_nxt = STALL;
      STALL:   if (!full)           state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  // A stalled key is re-read when space opens; it is pushed only if it still differs.
  always_comb begin
    push    = 1'b0;
    advance = 1'b0;
    case (state)
      SCAN: begin
        push    = differs && !full;
        advance = !differs || !full;
      end
      STALL: begin
        push    = differs && !full;
        advance = !full;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr  <= '0;
      snap <= '0;
    end else begin
      if (push) snap[ptr] <= level_now;
      if (advance) ptr <= (ptr == IDXW'(KEYS - 1)) ? '0 : ptr + 1'b1;
    end
  end

  key_event_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .pop       (event_ready_i),
    .valid     (event_valid_o),
    .pop_data  (head),
    .level     (fifo_level_o)
  );

endmodule

// File: tb/tb_key_event_encoder.sv
// tb/tb_key_event_encoder.sv - directed table-driven bench for key_event_encoder
module tb_key_event_encoder;
  import key_event_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [60:0] keys;
  logic        event_valid;
  logic        event_ready;
  logic [6:0]  event_data;
  logic [3:0]  fifo_level;
  logic        stall;

  int checks = 0;
  int failures = 0;
  logic [6:0] got[$];

  typedef struct {
    int         key;
    bit         level;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   klist[10] = '{2, 7, 11, 20, 25, 31, 40, 47, 52, 59};

  key_event_encoder dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .keys_i        (keys),
    .event_valid_o (event_valid),
    .event_ready_i (event_ready),
    .event_o       (event_data),
    .fifo_level_o  (fifo_level),
    .stall_o       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && event_valid && event_ready) got.push_back(event_data);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  function automatic logic [6:0] ev(input bit p, input int k);
    key_event_t e;
    e.pressed = p;
    e.idx     = 6'(k);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return 32'(got[i]);
    return 32'hFFFF;
  endfunction

  task automatic apply_reset(input logic [60:0] kv);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    keys  = kv;
    got.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_events(input int n, input int budget, input string name);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(got.size() >= n), 32'd1);
  endtask

  initial begin
    logic [60:0] pat;
    bit          seen;

    vecs[0] = '{5,  1'b1, ev(1, 5)};
    vecs[1] = '{5,  1'b0, ev(0, 5)};
    vecs[2] = '{0,  1'b1, ev(1, 0)};
    vecs[3] = '{60, 1'b1, ev(1, 60)};
    vecs[4] = '{0,  1'b0, ev(0, 0)};
    vecs[5] = '{60, 1'b0, ev(0, 60)};
    vecs[6] = '{33, 1'b1, ev(1, 33)};
    vecs[7] = '{33, 1'b0, ev(0, 33)};

    rst_n       = 1'b0;
    keys        = '0;
    event_ready = 1'b1;

    // Idle: no events with all keys released
    apply_reset('0);
    @(negedge clk);
    check("reset_level", 32'(fifo_level), 32'd0);
    check("reset_valid", 32'(event_valid), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_event", 32'(event_data), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (event_valid || fifo_level != 0) seen = 1'b1;
    end
    check("idle_no_event", 32'(seen), 32'd0);

    // Single-key toggles from the table
    for (int i = 0; i < 8; i++) begin
      got.delete();
      @(posedge clk);
      #1;
      keys[vecs[i].key] = vecs[i].level;
      wait_events(1, 130, $sformatf("vec%0d_arrive", i));
      check($sformatf("vec%0d_event", i), got_at(0), 32'(vecs[i].exp));
      repeat (70) @(negedge clk);
      check($sformatf("vec%0d_count", i), 32'(got.size()), 32'd1);
    end

    // Keys held through reset are reported in scan order
    pat = '0;
    pat[0] = 1'b1;
    pat[60] = 1'b1;
    apply_reset(pat);
    wait_events(2, 130, "held_arrive");
    check("held_first", got_at(0), 32'(ev(1, 0)));
    check("held_second", got_at(1), 32'(ev(1, 60)));

    // A pulse shorter than one scan lap is invisible
    apply_reset('0);
    repeat (28) @(posedge clk);
    #1;
    keys[3] = 1'b1;
    @(posedge clk);
    #1;
    keys[3] = 1'b0;
    repeat (130) @(negedge clk);
    check("pulse_no_event", 32'(got.size()), 32'd0);

    // Ten presses against a blocked consumer saturate the FIFO
    pat = '0;
    foreach (klist[i]) pat[klist[i]] = 1'b1;
    event_ready = 1'b0;
    apply_reset(pat);
    repeat (80) @(negedge clk);
    check("sat_level", 32'(fifo_level), 32'd8);
    check("sat_stall", 32'(stall), 32'd1);
    check("sat_head_held", 32'(event_data), 32'(ev(1, 2)));

    // One pop from full: push is deferred a cycle
    @(posedge clk);
    #1;
    event_ready = 1'b1;
    @(negedge clk);
    check("pop_pre_level", 32'(fifo_level), 32'd8);
    @(posedge clk);
    #1;
    event_ready = 1'b0;
    @(negedge clk);
    check("pop_level_dip", 32'(fifo_level), 32'd7);
    check("pop_still_stall", 32'(stall), 32'd1);
    check("pop_new_head", 32'(event_data), 32'(ev(1, 7)));
    @(negedge clk);
    check("deferred_push_level", 32'(fifo_level), 32'd8);

    // Drain everything and confirm order
    @(posedge clk);
    #1;
    event_ready = 1'b1;
    wait_events(10, 300, "drain_arrive");
    for (int i = 0; i < 10; i++)
      check($sformatf("drain_order%0d", i), got_at(i), 32'(ev(1, klist[i])));
    repeat (80) @(negedge clk);
    check("drain_count", 32'(got.size()), 32'd10);
    check("drain_level", 32'(fifo_level), 32'd0);

    // Reset asserted while stalled clears outputs immediately
    event_ready = 1'b0;
    apply_reset(pat);
    repeat (80) @(negedge clk);
    check("restall_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(event_valid), 32'd0);
    check("async_rst_level", 32'(fifo_level), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    check("async_rst_event", 32'(event_data), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
